// File: rtl/sgpr_retire_arbiter_pkg.sv
// Shared widths, retire-event payload and helpers for the SGPR retire arbiter.
// Also carries the shared SGPR/retire macros, guarded so an existing define file wins.
// No logic here; everything is compile-time.
`ifndef SGPR_ADDR_LENGTH
`define SGPR_ADDR_LENGTH 9
`endif
`ifndef WF_ID_LENGTH
`define WF_ID_LENGTH 6
`endif
`ifndef SGPR_MASK_1W
`define SGPR_MASK_1W 4'b0001
`endif
`ifndef SGPR_MASK_2W
`define SGPR_MASK_2W 4'b0011
`endif
`ifndef SGPR_MASK_4W
`define SGPR_MASK_4W 4'b1111
`endif
`ifndef RETIRE_SRC_SALU
`define RETIRE_SRC_SALU 1'b0
`endif
`ifndef RETIRE_SRC_LSU
`define RETIRE_SRC_LSU 1'b1
`endif

package sgpr_retire_arbiter_pkg;

   localparam int WF_ID_W = `WF_ID_LENGTH;
   localparam int ADDR_W  = `SGPR_ADDR_LENGTH;

   localparam logic [3:0] MASK_1W = `SGPR_MASK_1W;
   localparam logic [3:0] MASK_2W = `SGPR_MASK_2W;
   localparam logic [3:0] MASK_4W = `SGPR_MASK_4W;

   typedef enum logic {
      SRC_SALU = `RETIRE_SRC_SALU,
      SRC_LSU  = `RETIRE_SRC_LSU
   } retire_src_e;

   // One retirement event as carried through the FIFOs and onto the comparator port.
   typedef struct packed {
      logic [WF_ID_W-1:0] wfid;
      logic [ADDR_W-1:0]  addr;
      logic [3:0]         mask;
   } retire_ent_t;

   // Mask must be 1, 2 or 4 words and the base address aligned to that size.
   function automatic logic mask_legal(input logic [3:0] mask, input logic [ADDR_W-1:0] addr);
      logic ok;
      ok = 1'b0;
      case (mask)
         MASK_1W: ok = 1'b1;
         MASK_2W: ok = (addr[0] == 1'b0);
         MASK_4W: ok = (addr[1:0] == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/sgpr_retire_arbiter_if.sv
// Retire request channel from one producer (SALU or LSU) into the arbiter.
// Latency: none, plain wires.
// Backpressure: ready is owned by the arbiter side and reflects FIFO space only.
interface sgpr_retire_arbiter_if;
   import sgpr_retire_arbiter_pkg::*;

   logic               valid;
   logic               ready;
   logic [WF_ID_W-1:0] wfid;
   logic [ADDR_W-1:0]  addr;
   logic [3:0]         mask;

   modport master (output valid, output wfid, output addr, output mask, input ready);
   modport slave  (input valid, input wfid, input addr, input mask, output ready);
endinterface

// File: rtl/sgpr_retire_fifo.sv
// Small per-source FIFO of retire events; head is visible without popping.
// Latency: a pushed entry is at the head the cycle after the push edge (no bypass).
// Backpressure: full is derived from the registered count only; caller must not push when full.
module sgpr_retire_fifo
   import sgpr_retire_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  retire_ent_t   push_dat_i,
   input  logic          pop_i,
   output retire_ent_t   head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   retire_ent_t   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   // Pointer and occupancy next state; pointers wrap at the power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state, cleared asynchronously so reset discards queued entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: contents are only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/sgpr_retire_arbiter.sv
// Round-robin merge of SALU/LSU SGPR retire events onto the scoreboard comparator port.
// Latency: accept at edge E into an empty FIFO -> retired_operand_* valid after edge E+1.
// Backpressure: per-source ready = FIFO not full; retire_hold_i freezes output, pops and grant pointer.
module sgpr_retire_arbiter
   import sgpr_retire_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   sgpr_retire_arbiter_if.slave salu_if,
   sgpr_retire_arbiter_if.slave lsu_if,
   input  logic               retire_hold_i,
   output logic               retired_operand_valid_o,
   output logic [WF_ID_W-1:0] retired_operand_wfid_o,
   output logic [ADDR_W-1:0]  retired_operand_addr_o,
   output logic [3:0]         retired_operand_mask_o,
   output logic               retire_pending_o,
   output logic               retire_err_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   retire_ent_t   salu_in, lsu_in, salu_head, lsu_head, head;
   logic          salu_push, lsu_push, salu_pop, lsu_pop;
   logic          salu_full, lsu_full, salu_empty, lsu_empty;
   logic [CW-1:0] salu_count, lsu_count;

   logic          grant, head_legal;
   retire_src_e   grant_src;

   logic          out_vld_q, out_vld_d;
   retire_ent_t   out_ent_q, out_ent_d;
   logic          err_q, err_d;
   retire_src_e   last_grant_q, last_grant_d;

   assign salu_in = '{wfid: salu_if.wfid, addr: salu_if.addr, mask: salu_if.mask};
   assign lsu_in  = '{wfid: lsu_if.wfid,  addr: lsu_if.addr,  mask: lsu_if.mask};

   // Ready looks only at registered occupancy, so a full FIFO stays not-ready while draining.
   assign salu_if.ready = !rst && !salu_full;
   assign lsu_if.ready  = !rst && !lsu_full;
   assign salu_push     = salu_if.valid && salu_if.ready;
   assign lsu_push      = lsu_if.valid && lsu_if.ready;

   sgpr_retire_fifo #(.DEPTH(FIFO_DEPTH)) u_salu_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (salu_push),
      .push_dat_i (salu_in),
      .pop_i      (salu_pop),
      .head_o     (salu_head),
      .full_o     (salu_full),
      .empty_o    (salu_empty),
      .count_o    (salu_count)
   );

   sgpr_retire_fifo #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (lsu_push),
      .push_dat_i (lsu_in),
      .pop_i      (lsu_pop),
      .head_o     (lsu_head),
      .full_o     (lsu_full),
      .empty_o    (lsu_empty),
      .count_o    (lsu_count)
   );

   // Round-robin grant among non-empty FIFOs; on a tie the source not granted last wins.
   always_comb begin
      grant     = 1'b0;
      grant_src = last_grant_q;
      if (!retire_hold_i) begin
         if (!salu_empty && !lsu_empty) begin
            grant     = 1'b1;
            grant_src = (last_grant_q == SRC_SALU) ? SRC_LSU : SRC_SALU;
         end else if (!salu_empty) begin
            grant     = 1'b1;
            grant_src = SRC_SALU;
         end else if (!lsu_empty) begin
            grant     = 1'b1;
            grant_src = SRC_LSU;
         end
      end
   end

   assign salu_pop   = grant && (grant_src == SRC_SALU);
   assign lsu_pop    = grant && (grant_src == SRC_LSU);
   assign head       = (grant_src == SRC_LSU) ? lsu_head : salu_head;
   assign head_legal = mask_legal(head.mask, head.addr);

   // Output register, sticky error and grant pointer next state; hold freezes all but error.
   always_comb begin
      out_vld_d    = out_vld_q;
      out_ent_d    = out_ent_q;
      err_d        = err_q;
      last_grant_d = last_grant_q;
      if (grant) last_grant_d = grant_src;
      if (!retire_hold_i) begin
         out_vld_d = grant && head_legal;
         if (grant && head_legal) out_ent_d = head;
      end
      if (grant && !head_legal) err_d = 1'b1;
   end

   // State registers; reset drops the presented event and points last grant at LSU.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld_q    <= 1'b0;
         out_ent_q    <= '0;
         err_q        <= 1'b0;
         last_grant_q <= SRC_LSU;
      end else begin
         out_vld_q    <= out_vld_d;
         out_ent_q    <= out_ent_d;
         err_q        <= err_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign retired_operand_valid_o = out_vld_q;
   assign retired_operand_wfid_o  = out_ent_q.wfid;
   assign retired_operand_addr_o  = out_ent_q.addr;
   assign retired_operand_mask_o  = out_ent_q.mask;
   assign retire_err_o            = err_q;
   assign retire_pending_o        = (salu_count != '0) || (lsu_count != '0) || out_vld_q;

endmodule

// File: doc/sgpr_retire_arbiter.md
# sgpr_retire_arbiter

Merges SGPR write-retirement events from the SALU and LSU into the single retired-operand port that feeds the issue stage's per-wavefront SGPR scoreboard comparators. Each source has its own small FIFO with a valid/ready handshake. The block picks one event per cycle by round-robin, checks that its mask is legal and its address is aligned, and registers it onto the comparator port. It lives in the issue stage, between the retire paths and the scoreboard clear logic.

## Interface
- FIFO_DEPTH, 4, entries per source FIFO; power of two, ≥2
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- salu_retire_valid  in  1  SALU retire request
- salu_retire_ready  out  1  SALU FIFO can accept this cycle
- salu_retire_wfid  in  `WF_ID_LENGTH  wavefront id
- salu_retire_addr  in  `SGPR_ADDR_LENGTH  base SGPR address
- salu_retire_mask  in  4  word mask (4'b0001, 4'b0011 or 4'b1111)
- lsu_retire_valid / lsu_retire_ready / lsu_retire_wfid / lsu_retire_addr / lsu_retire_mask: same widths and meaning, LSU side
- retire_hold  in  1  scoreboard cannot consume; freezes the output stage
- retired_operand_valid  out  1  comparator port valid
- retired_operand_wfid  out  `WF_ID_LENGTH  wavefront whose scoreboard is cleared
- retired_operand_addr  out  `SGPR_ADDR_LENGTH  base address to comparators
- retired_operand_mask  out  4  mask to comparators
- retire_pending  out  1  any FIFO non-empty or retired_operand_valid high
- retire_err  out  1  sticky illegal-mask or misalignment flag

## Operation
- Enqueue: an entry is accepted when x_retire_valid && x_retire_ready at the clock edge.
- x_retire_ready = !rst && (count_x != FIFO_DEPTH). It depends only on registered count, never on valid or on a dequeue in the same cycle, so a full FIFO shows ready=0 even while it drains.
- Arbitration happens each cycle when retire_hold=0:
  - Requesters are the non-empty FIFOs.
  - If both are non-empty, grant the source not granted last.
  - If one is non-empty, grant it.
  - last_grant updates only on a grant. Its reset value is LSU, so SALU wins the first tie.
- The granted head is popped and checked:
  - Legal: the mask is one of 0001/0011/1111, and the address is aligned (0011 needs addr[0]=0; 1111 needs addr[1:0]=0). The entry loads the output register with retired_operand_valid=1.
  - Illegal: the entry is dropped, retired_operand_valid=0 next cycle, and retire_err is set.
- If no grant occurs and retire_hold=0, retired_operand_valid goes to 0 next cycle.
- Hold: while retire_hold=1, the output register (valid and payload) keeps its value, nothing is dequeued, enqueue continues and last_grant is frozen. Each event is presented for exactly one non-held cycle.
- retire_err stays 1 until rst.
- FIFO pointers are clog2(FIFO_DEPTH) bits and wrap naturally. The count is clog2(FIFO_DEPTH)+1 bits.
- Simultaneous enqueue and dequeue on the same FIFO leaves the count unchanged.

## Timing
- Reset values (asynchronous): retired_operand_valid=0, wfid/addr/mask=0, retire_err=0, retire_pending=0, both readys=0 while rst=1, counts/pointers=0, last_grant=LSU.
- The first cycle after rst deasserts: both readys are 1.
- Latency: an entry accepted at edge E into an empty FIFO with no hold appears on retired_operand_* after edge E+1. There is no same-cycle bypass.
- Throughput: one event per cycle sustained. With both sources saturated the output alternates SALU/LSU.
- retire_pending is combinational from the registered state.
- rst asserted mid-operation discards all queued and presented events immediately.

## Structure
- Sub-module sgpr_retire_fifo, instantiated twice. Payload {wfid, addr, mask}, signals push/pop/full/empty/count, head output visible without a pop.
- The top level holds the arbiter, the legality check and the output register.
- Shared define file already provides `SGPR_ADDR_LENGTH and `WF_ID_LENGTH. Add to it:
  - `SGPR_MASK_1W=4'b0001, `SGPR_MASK_2W=4'b0011, `SGPR_MASK_4W=4'b1111
  - `RETIRE_SRC_SALU=1'b0, `RETIRE_SRC_LSU=1'b1

## Test plan
- Single SALU push (wfid=3, addr=9'd20, mask=0011) at edge E → retired_operand_valid=1 with the same payload after edge E+1 only, retire_pending falls one cycle later.
- Both FIFOs preloaded with 3 entries, no hold → output order SALU0, LSU0, SALU1, LSU1, SALU2, LSU2 on 6 consecutive cycles.
- Push 4 SALU entries with hold=1 → salu_retire_ready=0 after the 4th acceptance. Release hold → exactly 4 outputs, ready returns to 1 the cycle after the first pop.
- Hold asserted while valid=1 with addr=9'd8 for 5 cycles → output stable for all 5 cycles, then each pending event appears exactly once.
- LSU push mask=0101, then 1111 with addr=9'd6 → both dropped, no retired_operand_valid, retire_err=1 and still 1 after 10 idle cycles.
- rst pulsed mid-stream with both FIFOs holding 2 entries → all outputs 0 at once, no stale entry appears after release.
